// File: rtl/i_mem_fill_arb.sv
// i_mem_fill_arb: arbitrates demand and prefetch instruction-line fill requests
// onto a single i_mem port with at most one outstanding memory transaction.
// A demand that hits the line already being prefetched merges into it.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   dmd_req_valid/addr/ready      demand fill request channel
//   pf_req_valid/addr/ready       prefetch fill request channel
//   dmd_rsp_valid/tag/data        demand fill response (one-cycle pulse)
//   pf_rsp_valid/tag/data         prefetch fill response (one-cycle pulse)
//   mem_req_valid/addr/ready      line-aligned request to i_mem
//   mem_rsp_valid/data            i_mem line response
//   busy                          transaction in flight
//   timeout_err                   sticky: a WAIT timeout has occurred
module i_mem_fill_arb #(
  parameter int unsigned CL_WIDTH    = 128,
  parameter int unsigned TIMEOUT_CYC = 256,
  localparam int unsigned ADDR_W     = 32,
  localparam int unsigned TAG_W      = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dmd_req_valid,
  input  logic [ADDR_W-1:0]   dmd_req_addr,
  output logic                dmd_req_ready,
  input  logic                pf_req_valid,
  input  logic [ADDR_W-1:0]   pf_req_addr,
  output logic                pf_req_ready,
  output logic                dmd_rsp_valid,
  output logic [TAG_W-1:0]    dmd_rsp_tag,
  output logic [CL_WIDTH-1:0] dmd_rsp_data,
  output logic                pf_rsp_valid,
  output logic [TAG_W-1:0]    pf_rsp_tag,
  output logic [CL_WIDTH-1:0] pf_rsp_data,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_req_ready,
  input  logic                mem_rsp_valid,
  input  logic [CL_WIDTH-1:0] mem_rsp_data,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TAG_W-1:0] tag;
  logic             owner_pf;
  logic             merged;
  logic [CNT_W-1:0] cnt;
  logic             merge_c;
  logic             timeout_c;
  logic             unused_addr_lsbs;

  // Byte offset within the line never affects the fill.
  assign unused_addr_lsbs = ^{dmd_req_addr[3:0], pf_req_addr[3:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, request-channel readiness and memory request strobe.
  always_comb begin
    state_nxt     = state;
    dmd_req_ready = 1'b0;
    pf_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    merge_c       = 1'b0;
    timeout_c     = 1'b0;
    case (state)
      IDLE: begin
        dmd_req_ready = 1'b1;
        pf_req_ready  = !dmd_req_valid;
        if (dmd_req_valid || pf_req_valid) state_nxt = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_nxt = RSP;
        end else if (cnt == CNT_LAST) begin
          timeout_c = 1'b1;
          state_nxt = REQ;
        end
      end
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A demand for the line already being prefetched rides on that fill.
    if ((state == REQ || state == WAIT) && owner_pf && dmd_req_valid &&
        dmd_req_addr[ADDR_W-1:4] == tag) begin
      merge_c       = 1'b1;
      dmd_req_ready = 1'b1;
    end
  end

  assign mem_req_addr  = {tag, 4'b0000};
  assign busy          = (state != IDLE);
  assign dmd_rsp_valid = (state == RSP) && (!owner_pf || merged);
  assign pf_rsp_valid  = (state == RSP) && owner_pf;

  // Transaction context, timeout counter and per-channel response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag          <= '0;
      owner_pf     <= 1'b0;
      merged       <= 1'b0;
      cnt          <= '0;
      timeout_err  <= 1'b0;
      dmd_rsp_tag  <= '0;
      dmd_rsp_data <= '0;
      pf_rsp_tag   <= '0;
      pf_rsp_data  <= '0;
    end else begin
      if (state == IDLE) begin
        merged <= 1'b0;
        if (dmd_req_valid) begin
          tag      <= dmd_req_addr[ADDR_W-1:4];
          owner_pf <= 1'b0;
        end else if (pf_req_valid) begin
          tag      <= pf_req_addr[ADDR_W-1:4];
          owner_pf <= 1'b1;
        end
      end else if (merge_c) begin
        merged <= 1'b1;
      end

      if (state == REQ)       cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CNT_W'(1);

      if (timeout_c) timeout_err <= 1'b1;

      // Response registers hold their value between pulses.
      if (state == WAIT && mem_rsp_valid) begin
        if (!owner_pf || merged || merge_c) begin
          dmd_rsp_tag  <= tag;
          dmd_rsp_data <= mem_rsp_data;
        end
        if (owner_pf) begin
          pf_rsp_tag  <= tag;
          pf_rsp_data <= mem_rsp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_i_mem_fill_arb.sv
// Self-checking bench for i_mem_fill_arb: a behavioural i_mem model with
// configurable latency, a response monitor feeding an observed queue, and
// per-scenario tasks that push expected responses and compare on completion.
module tb_i_mem_fill_arb;

  localparam int unsigned CL = 128;
  localparam int unsigned TO = 8;

  typedef struct {
    logic          dv;
    logic          pv;
    logic [27:0]   dtag;
    logic [27:0]   ptag;
    logic [CL-1:0] ddata;
    logic [CL-1:0] pdata;
    int            cyc;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dmd_req_valid = 1'b0;
  logic [31:0]   dmd_req_addr = '0;
  logic          dmd_req_ready;
  logic          pf_req_valid = 1'b0;
  logic [31:0]   pf_req_addr = '0;
  logic          pf_req_ready;
  logic          dmd_rsp_valid;
  logic [27:0]   dmd_rsp_tag;
  logic [CL-1:0] dmd_rsp_data;
  logic          pf_rsp_valid;
  logic [27:0]   pf_rsp_tag;
  logic [CL-1:0] pf_rsp_data;
  logic          mem_req_valid;
  logic [31:0]   mem_req_addr;
  logic          mem_req_ready;
  logic          mem_rsp_valid = 1'b0;
  logic [CL-1:0] mem_rsp_data = '0;
  logic          busy;
  logic          timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  rsp_t        obs_q[$];
  rsp_t        exp_q[$];
  logic [31:0] mem_log[$];

  // i_mem model controls
  bit            mem_rdy_en = 1'b1;
  bit            mem_drop   = 1'b0;
  bit            mem_fix    = 1'b0;
  int            mem_lat    = 1;
  logic [CL-1:0] mem_data_v = '0;
  int            m_cnt      = 0;
  logic [31:0]   m_addr     = '0;

  i_mem_fill_arb #(.CL_WIDTH(CL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .dmd_req_valid(dmd_req_valid), .dmd_req_addr(dmd_req_addr), .dmd_req_ready(dmd_req_ready),
    .pf_req_valid(pf_req_valid), .pf_req_addr(pf_req_addr), .pf_req_ready(pf_req_ready),
    .dmd_rsp_valid(dmd_rsp_valid), .dmd_rsp_tag(dmd_rsp_tag), .dmd_rsp_data(dmd_rsp_data),
    .pf_rsp_valid(pf_rsp_valid), .pf_rsp_tag(pf_rsp_tag), .pf_rsp_data(pf_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_req_ready = mem_rdy_en;

  // i_mem model: a handshake seen in cycle H responds in cycle H+mem_lat.
  always @(negedge clk) begin
    mem_rsp_valid = 1'b0;
    if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_fix ? mem_data_v : {4{~m_addr}};
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      mem_log.push_back(mem_req_addr);
      m_addr = mem_req_addr;
      if (!mem_drop) m_cnt = mem_lat;
    end
  end

  // Response monitor: every cycle with a response pulse becomes one entry.
  always @(negedge clk) begin
    if (dmd_rsp_valid || pf_rsp_valid)
      obs_q.push_back('{dmd_rsp_valid, pf_rsp_valid, dmd_rsp_tag, pf_rsp_tag,
                        dmd_rsp_data, pf_rsp_data, cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_queues();
    obs_q.delete();
    exp_q.delete();
    mem_log.delete();
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dmd_req_valid = 1'b0; pf_req_valid = 1'b0;
    dmd_req_addr = '0; pf_req_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    n_tests++; if ({mem_req_valid, dmd_rsp_valid, pf_rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_valids: got %b want 000", {mem_req_valid, dmd_rsp_valid, pf_rsp_valid}); end
    n_tests++; if ({dmd_rsp_tag, pf_rsp_tag} !== 56'h0) begin n_fail++; $display("FAIL reset_tags: got %h want 0", {dmd_rsp_tag, pf_rsp_tag}); end
    n_tests++; if ((dmd_rsp_data | pf_rsp_data) !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", dmd_rsp_data | pf_rsp_data); end
    n_tests++; if ({dmd_req_ready, pf_req_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b want 11", {dmd_req_ready, pf_req_ready}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_demand_miss();
    int hs; bit ok; rsp_t o, e; logic [31:0] a0;
    clear_queues();
    mem_fix = 1'b1; mem_data_v = {32{4'hA}}; mem_lat = 3; mem_drop = 1'b0;
    @(negedge clk);
    dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_1234;
    #1;
    n_tests++; if (dmd_req_ready !== 1'b1) begin n_fail++; $display("FAIL miss_dmd_ready: got %b want 1", dmd_req_ready); end
    hs = cyc;
    exp_q.push_back('{1'b1, 1'b0, 28'h000_0123, 28'h0, {32{4'hA}}, '0, hs + 5});
    @(negedge clk);
    dmd_req_valid = 1'b0; dmd_req_addr = '0;
    n_tests++; if ({busy, mem_req_valid} !== 2'b11) begin n_fail++; $display("FAIL miss_req_phase: got busy,mem_req_valid=%b want 11", {busy, mem_req_valid}); end
    n_tests++; if (mem_req_addr !== 32'h0000_1230) begin n_fail++; $display("FAIL miss_mem_addr: got %h want 00001230", mem_req_addr); end
    wait_idle(40, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL miss_idle_timeout: got busy want idle within 40 cycles"); end
    a0 = (mem_log.size() > 0) ? mem_log[0] : 32'hx;
    n_tests++; if (mem_log.size() != 1 || a0 !== 32'h0000_1230) begin n_fail++; $display("FAIL miss_mem_log: got %0d reqs first %h want 1 req 00001230", mem_log.size(), a0); end
    n_tests++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL miss_pulse_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{default: 0};
    e = exp_q.pop_front();
    n_tests++; if ({o.dv, o.pv} !== {e.dv, e.pv}) begin n_fail++; $display("FAIL miss_valids: got %b want %b", {o.dv, o.pv}, {e.dv, e.pv}); end
    n_tests++; if (o.dtag !== e.dtag) begin n_fail++; $display("FAIL miss_tag: got %h want %h", o.dtag, e.dtag); end
    n_tests++; if (o.ddata !== e.ddata) begin n_fail++; $display("FAIL miss_data: got %h want %h", o.ddata, e.ddata); end
    n_tests++; if (o.cyc != e.cyc) begin n_fail++; $display("FAIL miss_latency: got cycle %0d want %0d", o.cyc, e.cyc); end
    n_tests++; if (dmd_rsp_valid !== 1'b0 || dmd_rsp_tag !== 28'h000_0123) begin n_fail++; $display("FAIL miss_hold: got valid %b tag %h want 0 0000123", dmd_rsp_valid, dmd_rsp_tag); end
    mem_fix = 1'b0;
  endtask

  task automatic test_contention();
    int hs, pf_hs; bit ok, pf_done; rsp_t o, e; logic [31:0] a0, a1;
    clear_queues();
    mem_lat = 2;
    @(negedge clk);
    dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_0100;
    pf_req_valid  = 1'b1; pf_req_addr  = 32'h0000_0200;
    #1;
    n_tests++; if ({dmd_req_ready, pf_req_ready} !== 2'b10) begin n_fail++; $display("FAIL cont_grant: got dmd,pf ready=%b want 10", {dmd_req_ready, pf_req_ready}); end
    hs = cyc;
    exp_q.push_back('{1'b1, 1'b0, 28'h000_0010, 28'h0, {4{~32'h100}}, '0, hs + 4});
    exp_q.push_back('{1'b0, 1'b1, 28'h0, 28'h000_0020, '0, {4{~32'h200}}, hs + 9});
    @(negedge clk);
    dmd_req_valid = 1'b0;
    #1;
    n_tests++; if (pf_req_ready !== 1'b0) begin n_fail++; $display("FAIL cont_pf_blocked: got %b want 0", pf_req_ready); end
    pf_done = 1'b0; pf_hs = -1;
    for (int i = 0; i < 30 && !pf_done; i++) begin
      @(negedge clk); #1;
      if (pf_req_ready) begin pf_hs = cyc; pf_done = 1'b1; end
    end
    @(negedge clk);
    pf_req_valid = 1'b0;
    n_tests++; if (pf_hs != hs + 5) begin n_fail++; $display("FAIL cont_pf_accept: got cycle %0d want %0d", pf_hs, hs + 5); end
    wait_idle(40, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL cont_idle_timeout: got busy want idle within 40 cycles"); end
    a0 = (mem_log.size() > 0) ? mem_log[0] : 32'hx;
    a1 = (mem_log.size() > 1) ? mem_log[1] : 32'hx;
    n_tests++; if (mem_log.size() != 2 || a0 !== 32'h100 || a1 !== 32'h200) begin n_fail++; $display("FAIL cont_mem_order: got %0d reqs %h %h want 2 reqs 100 200", mem_log.size(), a0, a1); end
    n_tests++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL cont_rsp_count: got %0d want 2", obs_q.size()); end
    if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{default: 0};
    e = exp_q.pop_front();
    n_tests++; if ({o.dv, o.pv, o.dtag, o.cyc} !== {e.dv, e.pv, e.dtag, e.cyc} || o.ddata !== e.ddata) begin n_fail++; $display("FAIL cont_dmd_rsp: got v=%b tag=%h cyc=%0d want v=%b tag=%h cyc=%0d", {o.dv, o.pv}, o.dtag, o.cyc, {e.dv, e.pv}, e.dtag, e.cyc); end
    if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{default: 0};
    e = exp_q.pop_front();
    n_tests++; if ({o.dv, o.pv, o.ptag, o.cyc} !== {e.dv, e.pv, e.ptag, e.cyc} || o.pdata !== e.pdata) begin n_fail++; $display("FAIL cont_pf_rsp: got v=%b tag=%h cyc=%0d want v=%b tag=%h cyc=%0d", {o.dv, o.pv}, o.ptag, o.cyc, {e.dv, e.pv}, e.ptag, e.cyc); end
  endtask

  task automatic test_merge();
    int hs; bit ok; rsp_t o, e; logic [31:0] a0;
    clear_queues();
    mem_lat = 5;
    @(negedge clk);
    pf_req_valid = 1'b1; pf_req_addr = 32'h0000_0400;
    #1;
    n_tests++; if (pf_req_ready !== 1'b1) begin n_fail++; $display("FAIL merge_pf_ready: got %b want 1", pf_req_ready); end
    hs = cyc;
    exp_q.push_back('{1'b1, 1'b1, 28'h000_0040, 28'h000_0040, {4{~32'h400}}, {4{~32'h400}}, hs + 7});
    @(negedge clk);
    pf_req_valid = 1'b0;
    @(negedge clk);
    dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_040C;
    #1;
    n_tests++; if ({busy, dmd_req_ready} !== 2'b11) begin n_fail++; $display("FAIL merge_dmd_ready: got busy,ready=%b want 11", {busy, dmd_req_ready}); end
    @(negedge clk);
    dmd_req_valid = 1'b0;
    wait_idle(40, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL merge_idle_timeout: got busy want idle within 40 cycles"); end
    a0 = (mem_log.size() > 0) ? mem_log[0] : 32'hx;
    n_tests++; if (mem_log.size() != 1 || a0 !== 32'h400) begin n_fail++; $display("FAIL merge_single_req: got %0d reqs first %h want 1 req 400", mem_log.size(), a0); end
    n_tests++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL merge_rsp_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{default: 0};
    e = exp_q.pop_front();
    n_tests++; if ({o.dv, o.pv} !== 2'b11) begin n_fail++; $display("FAIL merge_both_valid: got %b want 11", {o.dv, o.pv}); end
    n_tests++; if (o.dtag !== e.dtag || o.ptag !== e.ptag) begin n_fail++; $display("FAIL merge_tags: got %h %h want %h", o.dtag, o.ptag, e.dtag); end
    n_tests++; if (o.ddata !== e.ddata || o.pdata !== e.pdata) begin n_fail++; $display("FAIL merge_data: got %h want %h", o.ddata, e.ddata); end
    n_tests++; if (o.cyc != e.cyc) begin n_fail++; $display("FAIL merge_cycle: got %0d want %0d", o.cyc, e.cyc); end
  endtask

  task automatic test_nomatch();
    int hs, d_hs; bit ok, bad, d_done; rsp_t o, e; logic [31:0] a0, a1;
    clear_queues();
    mem_lat = 4;
    @(negedge clk);
    pf_req_valid = 1'b1; pf_req_addr = 32'h0000_0500;
    #1;
    hs = cyc;
    exp_q.push_back('{1'b0, 1'b1, 28'h0, 28'h000_0050, '0, {4{~32'h500}}, hs + 6});
    @(negedge clk);
    pf_req_valid = 1'b0;
    @(negedge clk);
    dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_0800;
    bad = 1'b0; d_done = 1'b0; d_hs = -1;
    for (int i = 0; i < 30 && !d_done; i++) begin
      #1;
      if (busy) begin
        if (dmd_req_ready || pf_req_ready) bad = 1'b1;
      end else if (dmd_req_ready) begin
        d_hs = cyc; d_done = 1'b1;
      end
      if (!d_done) @(negedge clk);
    end
    exp_q.push_back('{1'b1, 1'b0, 28'h000_0080, 28'h0, {4{~32'h800}}, '0, d_hs + 6});
    @(negedge clk);
    dmd_req_valid = 1'b0;
    n_tests++; if (bad) begin n_fail++; $display("FAIL nomatch_ready_busy: got ready=1 while busy want 0"); end
    n_tests++; if (d_hs != hs + 7) begin n_fail++; $display("FAIL nomatch_accept: got cycle %0d want %0d", d_hs, hs + 7); end
    wait_idle(40, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL nomatch_idle_timeout: got busy want idle within 40 cycles"); end
    a0 = (mem_log.size() > 0) ? mem_log[0] : 32'hx;
    a1 = (mem_log.size() > 1) ? mem_log[1] : 32'hx;
    n_tests++; if (mem_log.size() != 2 || a0 !== 32'h500 || a1 !== 32'h800) begin n_fail++; $display("FAIL nomatch_mem_order: got %0d reqs %h %h want 2 reqs 500 800", mem_log.size(), a0, a1); end
    n_tests++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL nomatch_rsp_count: got %0d want 2", obs_q.size()); end
    if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{default: 0};
    e = exp_q.pop_front();
    n_tests++; if ({o.dv, o.pv, o.ptag, o.cyc} !== {e.dv, e.pv, e.ptag, e.cyc} || o.pdata !== e.pdata) begin n_fail++; $display("FAIL nomatch_pf_rsp: got v=%b tag=%h cyc=%0d want v=%b tag=%h cyc=%0d", {o.dv, o.pv}, o.ptag, o.cyc, {e.dv, e.pv}, e.ptag, e.cyc); end
    if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{default: 0};
    e = exp_q.pop_front();
    n_tests++; if ({o.dv, o.pv, o.dtag, o.cyc} !== {e.dv, e.pv, e.dtag, e.cyc} || o.ddata !== e.ddata) begin n_fail++; $display("FAIL nomatch_dmd_rsp: got v=%b tag=%h cyc=%0d want v=%b tag=%h cyc=%0d", {o.dv, o.pv}, o.dtag, o.cyc, {e.dv, e.pv}, e.dtag, e.cyc); end
  endtask

  task automatic test_timeout();
    int hs, t_cyc; bit ok, seen, t_mv; rsp_t o, e; logic [31:0] t_ma, a0, a1;
    clear_queues();
    mem_lat = 3; mem_drop = 1'b1;
    @(negedge clk);
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_initial: got %b want 0", timeout_err); end
    dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_0900;
    #1;
    hs = cyc;
    exp_q.push_back('{1'b1, 1'b0, 28'h000_0090, 28'h0, {4{~32'h900}}, '0, hs + 14});
    @(negedge clk);
    dmd_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    mem_drop = 1'b0;
    seen = 1'b0; t_cyc = -1; t_mv = 1'b0; t_ma = '0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        seen = 1'b1; t_cyc = cyc; t_mv = mem_req_valid; t_ma = mem_req_addr;
      end
    end
    n_tests++; if (t_cyc != hs + 10) begin n_fail++; $display("FAIL to_assert_cycle: got %0d want %0d", t_cyc, hs + 10); end
    n_tests++; if (t_mv !== 1'b1 || t_ma !== 32'h900) begin n_fail++; $display("FAIL to_reissue: got valid %b addr %h want 1 900", t_mv, t_ma); end
    wait_idle(40, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL to_idle_timeout: got busy want idle within 40 cycles"); end
    a0 = (mem_log.size() > 0) ? mem_log[0] : 32'hx;
    a1 = (mem_log.size() > 1) ? mem_log[1] : 32'hx;
    n_tests++; if (mem_log.size() != 2 || a0 !== 32'h900 || a1 !== 32'h900) begin n_fail++; $display("FAIL to_mem_reqs: got %0d reqs %h %h want 2 reqs 900 900", mem_log.size(), a0, a1); end
    n_tests++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL to_rsp_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{default: 0};
    e = exp_q.pop_front();
    n_tests++; if ({o.dv, o.pv, o.dtag, o.cyc} !== {e.dv, e.pv, e.dtag, e.cyc} || o.ddata !== e.ddata) begin n_fail++; $display("FAIL to_rsp: got v=%b tag=%h cyc=%0d want v=%b tag=%h cyc=%0d", {o.dv, o.pv}, o.dtag, o.cyc, {e.dv, e.pv}, e.dtag, e.cyc); end
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    mem_lat = 4; mem_drop = 1'b0;
    @(negedge clk);
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL rmid_sticky_before: got %b want 1", timeout_err); end
    dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_0A00;
    @(negedge clk);
    dmd_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rmid_no_rsp: got %0d pulses want 0", obs_q.size()); end
    n_tests++; if ({busy, timeout_err, mem_req_valid} !== 3'b000) begin n_fail++; $display("FAIL rmid_state: got busy,terr,mreq=%b want 000", {busy, timeout_err, mem_req_valid}); end
    n_tests++; if (dmd_rsp_tag !== 28'h0) begin n_fail++; $display("FAIL rmid_tag_cleared: got %h want 0", dmd_rsp_tag); end
    n_tests++; if (mem_log.size() != 1) begin n_fail++; $display("FAIL rmid_mem_reqs: got %0d want 1", mem_log.size()); end
  endtask

  task automatic test_back_to_back();
    int hs, hs2; bit ok, done; rsp_t o, e;
    clear_queues();
    mem_lat = 1;
    @(negedge clk);
    dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_0B04;
    #1;
    hs = cyc;
    exp_q.push_back('{1'b1, 1'b0, 28'h000_00B0, 28'h0, {4{~32'hB00}}, '0, hs + 3});
    @(negedge clk);
    dmd_req_addr = 32'h0000_0C08;
    #1;
    n_tests++; if (dmd_req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_blocked: got %b want 0", dmd_req_ready); end
    done = 1'b0; hs2 = -1;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk); #1;
      if (dmd_req_ready) begin hs2 = cyc; done = 1'b1; end
    end
    exp_q.push_back('{1'b1, 1'b0, 28'h000_00C0, 28'h0, {4{~32'hC00}}, '0, hs2 + 3});
    @(negedge clk);
    dmd_req_valid = 1'b0;
    n_tests++; if (hs2 != hs + 4) begin n_fail++; $display("FAIL b2b_accept: got cycle %0d want %0d", hs2, hs + 4); end
    wait_idle(40, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_idle_timeout: got busy want idle within 40 cycles"); end
    n_tests++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want 2", obs_q.size()); end
    for (int k = 0; k < 2; k++) begin
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{default: 0};
      e = exp_q.pop_front();
      n_tests++; if ({o.dv, o.pv, o.dtag, o.cyc} !== {e.dv, e.pv, e.dtag, e.cyc} || o.ddata !== e.ddata) begin n_fail++; $display("FAIL b2b_rsp%0d: got v=%b tag=%h cyc=%0d want v=%b tag=%h cyc=%0d", k, {o.dv, o.pv}, o.dtag, o.cyc, {e.dv, e.pv}, e.dtag, e.cyc); end
    end
  endtask

  initial begin
    test_reset();
    test_demand_miss();
    test_contention();
    test_merge();
    test_nomatch();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
